// File: rtl/jtframe_x2_vga_pkg.sv
// Shared types, widths and colour expansion helper for the x2 VGA output stage.
package jtframe_x2_vga_pkg;

  localparam int HCW = 11;  // horizontal counter width
  localparam int VCW = 10;  // vertical counter width

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  // Replicate a colour field MSB-first to fill 8 bits. The field arrives
  // left-aligned in c_al; bc is its width in bits.
  function automatic logic [7:0] expand_colour(input logic [7:0] c_al, input int bc);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[7-i] = c_al[7-(i % bc)];
    end
    return y;
  endfunction

endpackage

// File: rtl/jtframe_x2_linelen.sv
// Horizontal line length measurement and lock detector for the doubled HS.
module jtframe_x2_linelen
  import jtframe_x2_vga_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         pxl_cen,
  input  logic         hs,
  output logic         locked,
  output logic         hs_rise,
  output logic         hs_fall,
  output logic [HCW:0] len
);

  localparam logic [HCW-1:0] HMAX = '1;

  logic           r_hs_d;
  logic [HCW-1:0] r_hcnt;
  logic [HCW:0]   r_stored;
  lock_state_t    r_state;
  lock_state_t    w_next;
  logic           w_sat;
  logic           w_match;
  logic           w_store;

  assign hs_rise = pxl_cen &  hs & ~r_hs_d;
  assign hs_fall = pxl_cen & ~hs &  r_hs_d;
  assign len     = {1'b0, r_hcnt} + {{HCW{1'b0}}, 1'b1};
  assign w_match = (len == r_stored);
  // A rising edge on the saturating tick is a measurement, not a saturation.
  assign w_sat   = pxl_cen & ~hs_rise & (r_hcnt == HMAX);

  // HS edge register and saturating line counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    if (rst) begin
      r_hs_d <= 1'b0;
      r_hcnt <= '0;
    end else if (pxl_cen) begin
      r_hs_d <= hs;
      if (hs_rise)             r_hcnt <= '0;
      else if (r_hcnt != HMAX) r_hcnt <= r_hcnt + HCW'(1);
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst)          r_state <= SEARCH;
    else if (pxl_cen) r_state <= w_next;
  end

  // Lock FSM next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    case (r_state)
      SEARCH:  if (hs_rise) w_next = MEASURE;
      MEASURE: if (hs_rise && w_match) w_next = LOCKED;
      LOCKED:  if ((hs_rise && !w_match) || w_sat) w_next = MEASURE;
      default: w_next = SEARCH;
    endcase
  end

  // Lock FSM outputs: lock flag and reference-length capture strobe.
  always_comb begin
    locked  = (r_state == LOCKED);
    w_store = hs_rise && !w_match && (r_state != SEARCH);
  end

  // Reference line length, replaced on every mismatching measurement.
  always_ff @(posedge clk) begin
    if (rst)          r_stored <= '0;
    else if (w_store) r_stored <= len;
  end

endmodule

// File: rtl/jtframe_x2_vga.sv
// VGA output stage behind the scan doubler: lock detect, active window,
// colour expansion and a two-tick registered output pipeline.
module jtframe_x2_vga
  import jtframe_x2_vga_pkg::*;
#(
  parameter int DW   = 12,
  parameter int HBP  = 16,
  parameter int HACT = 512,
  parameter int VBP  = 32,
  parameter int VACT = 448
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic [DW-1:0] x2_pxl,
  input  logic          x2_HS,
  input  logic          VS,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic          locked
);

  localparam int BC = DW / 3;
  localparam logic [HCW-1:0] HLO   = HCW'(HBP);
  localparam logic [HCW-1:0] HHI   = HCW'(HBP + HACT - 1);
  localparam logic [HCW-1:0] HCMAX = '1;
  localparam logic [VCW-1:0] VLO   = VCW'(VBP);
  localparam logic [VCW-1:0] VHI   = VCW'(VBP + VACT - 1);
  localparam logic [VCW-1:0] VCMAX = '1;

  logic           w_hs_rise;
  logic           w_hs_fall;
  logic [HCW:0]   w_len_unused;
  logic           r_vs_d;
  logic           w_vs_fall;
  logic [HCW-1:0] r_hact;
  logic [VCW-1:0] r_vcnt;
  logic           w_de_int;
  logic [DW-1:0]  r_pxl1;
  logic           r_de1;
  logic           r_hs1;
  logic           r_vs1;
  logic [7:0]     w_r_al;
  logic [7:0]     w_g_al;
  logic [7:0]     w_b_al;

  jtframe_x2_linelen u_linelen (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .hs      (x2_HS),
    .locked  (locked),
    .hs_rise (w_hs_rise),
    .hs_fall (w_hs_fall),
    .len     (w_len_unused)
  );

  assign w_vs_fall = pxl_cen & ~VS & r_vs_d;
  assign w_de_int  = locked && (r_hact >= HLO) && (r_hact <= HHI)
                            && (r_vcnt >= VLO) && (r_vcnt <= VHI);

  // Left-align each colour field so the expansion works for any field width.
  assign w_r_al = 8'(r_pxl1[DW-1 -: BC])   << (8 - BC);
  assign w_g_al = 8'(r_pxl1[2*BC-1 -: BC]) << (8 - BC);
  assign w_b_al = 8'(r_pxl1[BC-1:0])       << (8 - BC);

  // VS edge register, pixels-since-HS-fall counter and line counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d <= 1'b0;
      r_hact <= '0;
      r_vcnt <= '0;
    end else if (pxl_cen) begin
      r_vs_d <= VS;
      if (w_hs_fall)            r_hact <= '0;
      else if (r_hact != HCMAX) r_hact <= r_hact + HCW'(1);
      // The VS clear wins over a coincident HS increment.
      if (w_vs_fall)                          r_vcnt <= '0;
      else if (w_hs_rise && r_vcnt != VCMAX)  r_vcnt <= r_vcnt + VCW'(1);
    end
  end

  // Pipeline stage 1: capture pixel, DE decision and syncs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pxl1 <= '0;
      r_de1  <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
    end else if (pxl_cen) begin
      r_pxl1 <= x2_pxl;
      r_de1  <= w_de_int;
      r_hs1  <= x2_HS;
      r_vs1  <= VS;
    end
  end

  // Pipeline stage 2: expanded, blanked colour and delayed syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else if (pxl_cen) begin
      vga_hs <= r_hs1;
      vga_vs <= r_vs1;
      vga_de <= r_de1;
      vga_r  <= r_de1 ? expand_colour(w_r_al, BC) : 8'h00;
      vga_g  <= r_de1 ? expand_colour(w_g_al, BC) : 8'h00;
      vga_b  <= r_de1 ? expand_colour(w_b_al, BC) : 8'h00;
    end
  end

endmodule
